// File: rtl/log_cmp_unit_if.sv
// Issue and writeback handshake bundle for the logic/compare execution unit.
// The master modport is the issue/writeback side; the slave modport is the unit.
interface log_cmp_unit_if #(
    parameter int XLEN  = 64,
    parameter int RNBIT = 2
);
    localparam int TAG_W  = 5 + RNBIT;
    localparam int INFO_W = 6 + TAG_W + 2 * XLEN + 2;

    logic              logCmp_execute_valid;
    logic              logCmp_execute_ready;
    logic [INFO_W-1:0] logCmp_execute_info;
    logic              logCmp_writeback_valid;
    logic              logCmp_writeback_ready;
    logic [XLEN-1:0]   logCmp_res;
    logic [TAG_W-1:0]  logCmp_rd0;

    modport master (
        output logCmp_execute_valid,
        output logCmp_execute_info,
        output logCmp_writeback_ready,
        input  logCmp_execute_ready,
        input  logCmp_writeback_valid,
        input  logCmp_res,
        input  logCmp_rd0
    );

    modport slave (
        input  logCmp_execute_valid,
        input  logCmp_execute_info,
        input  logCmp_writeback_ready,
        output logCmp_execute_ready,
        output logCmp_writeback_valid,
        output logCmp_res,
        output logCmp_rd0
    );
endinterface

// File: rtl/log_cmp_unit.sv
// Logic/compare execute unit: XOR/OR/AND/SLT/MIN/MAX with optional 32-bit word
// mode, results buffered in a DEPTH-entry FIFO towards writeback.
module log_cmp_unit #(
    parameter int XLEN  = 64,
    parameter int RNBIT = 2,
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           flush,
    log_cmp_unit_if.slave  io
);
    localparam int TAG_W = 5 + RNBIT;
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);

    // ---------------- issue bundle decode ----------------
    logic             funSlt, funXor, funOr, funAnd, funMin, funMax;
    logic [TAG_W-1:0] rdTag;
    logic [XLEN-1:0]  op1, op2;
    logic             isUsi, isWord;

    assign {funSlt, funXor, funOr, funAnd, funMin, funMax,
            rdTag, op1, op2, isUsi, isWord} = io.logCmp_execute_info;

    // ---------------- compare operands ----------------
    logic            wordMode;
    logic [XLEN-1:0] cmpA, cmpB;

    generate
        if (XLEN == 64) begin : gWordCmp
            assign wordMode = isWord;
            assign cmpA = wordMode ? {{32{op1[31] & ~isUsi}}, op1[31:0]} : op1;
            assign cmpB = wordMode ? {{32{op2[31] & ~isUsi}}, op2[31:0]} : op2;
        end else begin : gFullCmp
            assign wordMode = 1'b0;
            assign cmpA     = op1;
            assign cmpB     = op2;
        end
    endgenerate

    logic opLess, opEqual;

    assign opEqual = (cmpA == cmpB);
    assign opLess  = isUsi ? (cmpA < cmpB) : ($signed(cmpA) < $signed(cmpB));

    // ---------------- per-op results ----------------
    logic [XLEN-1:0] bitRes;
    logic [XLEN-1:0] wordRes;
    logic [XLEN-1:0] sltRes;
    logic [XLEN-1:0] opResult;

    always_comb begin
        bitRes = '0;
        if (funXor) bitRes = bitRes | (op1 ^ op2);
        if (funOr)  bitRes = bitRes | (op1 | op2);
        if (funAnd) bitRes = bitRes | (op1 & op2);
        // Ties pick op1 for both min and max.
        if (funMin) bitRes = bitRes | ((opLess | opEqual) ? op1 : op2);
        if (funMax) bitRes = bitRes | (opLess ? op2 : op1);
    end

    generate
        if (XLEN == 64) begin : gWordExt
            assign wordRes = wordMode ? {{32{bitRes[31]}}, bitRes[31:0]} : bitRes;
        end else begin : gNoWordExt
            assign wordRes = bitRes;
        end
    endgenerate

    // SLT is a plain 0/1 flag and is never widened by word mode.
    assign sltRes   = {{(XLEN-1){1'b0}}, funSlt & opLess};
    assign opResult = wordRes | sltRes;

    // ---------------- result FIFO control ----------------
    logic [PTR_W-1:0] wrPtr_reg, wrPtr_next;
    logic [PTR_W-1:0] rdPtr_reg, rdPtr_next;
    logic [PTR_W-1:0] count_reg, count_next;
    logic             execReady;
    logic             wbValid;
    logic             accept;
    logic             pop;

    assign execReady = (count_reg < FULL_COUNT);
    assign wbValid   = (count_reg != '0);
    assign accept    = io.logCmp_execute_valid & execReady & ~flush;
    assign pop       = wbValid & io.logCmp_writeback_ready & ~flush;

    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wrPtr_next = wrPtr_reg;
        rdPtr_next = rdPtr_reg;
        count_next = count_reg;
        if (flush) begin
            wrPtr_next = '0;
            rdPtr_next = '0;
            count_next = '0;
        end else begin
            if (accept) wrPtr_next = incPtr(wrPtr_reg);
            if (pop)    rdPtr_next = incPtr(rdPtr_reg);
            case ({accept, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_reg <= '0;
            rdPtr_reg <= '0;
            count_reg <= '0;
        end else begin
            wrPtr_reg <= wrPtr_next;
            rdPtr_reg <= rdPtr_next;
            count_reg <= count_next;
        end
    end

    // ---------------- result storage ----------------
    logic [XLEN-1:0]  resArr [DEPTH];
    logic [TAG_W-1:0] tagArr [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gEntry
            logic [XLEN-1:0]  res_reg;
            logic [TAG_W-1:0] tag_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    res_reg <= '0;
                    tag_reg <= '0;
                end else if (accept && (wrPtr_reg == PTR_W'(gi))) begin
                    res_reg <= opResult;
                    tag_reg <= rdTag;
                end
            end

            assign resArr[gi] = res_reg;
            assign tagArr[gi] = tag_reg;
        end
    endgenerate

    // Head is read combinationally so a result is visible the cycle after accept.
    logic [XLEN-1:0]  headRes;
    logic [TAG_W-1:0] headTag;

    always_comb begin
        headRes = '0;
        headTag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdPtr_reg == PTR_W'(i)) begin
                headRes = resArr[i];
                headTag = tagArr[i];
            end
        end
    end

    assign io.logCmp_execute_ready   = execReady;
    assign io.logCmp_writeback_valid = wbValid;
    assign io.logCmp_res             = headRes;
    assign io.logCmp_rd0             = headTag;
endmodule

// File: tb/tb_log_cmp_unit.sv
// Scoreboard bench for log_cmp_unit: a 64-bit (DEPTH 2) and a 32-bit (DEPTH 4)
// instance share the handshake stimulus; each has its own expected-result queue.
module tb_log_cmp_unit;
    localparam int DEPTH64 = 2;
    localparam int DEPTH32 = 4;

    logic CLK = 1'b0;
    logic RST;
    logic flush;

    always #5 CLK = ~CLK;

    log_cmp_unit_if #(.XLEN(64), .RNBIT(2)) bus64 ();
    log_cmp_unit_if #(.XLEN(32), .RNBIT(2)) bus32 ();

    log_cmp_unit #(.XLEN(64), .RNBIT(2), .DEPTH(DEPTH64)) dut64 (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .io    (bus64)
    );

    log_cmp_unit #(.XLEN(32), .RNBIT(2), .DEPTH(DEPTH32)) dut32 (
        .CLK   (CLK),
        .RST   (RST),
        .flush (flush),
        .io    (bus32)
    );

    typedef struct {
        logic [63:0] res;
        logic [6:0]  rd;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];
    int   tests = 0;
    int   fails = 0;
    bit   armed = 1'b0;

    localparam logic [5:0] F_SLT = 6'b100000;
    localparam logic [5:0] F_XOR = 6'b010000;
    localparam logic [5:0] F_OR  = 6'b001000;
    localparam logic [5:0] F_AND = 6'b000100;
    localparam logic [5:0] F_MIN = 6'b000010;
    localparam logic [5:0] F_MAX = 6'b000001;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: compare operands are the values (full width, or low word
    // sign/zero extended), then pick the operation's result.
    function automatic logic [63:0] refModel(input int xl, input logic [5:0] fun,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input bit usi, input bit word);
        logic [63:0] ca, cb, r;
        bit narrow, wm, lt;
        wm = word && (xl == 64);
        if (xl == 32) begin
            a = {32'h0, a[31:0]};
            b = {32'h0, b[31:0]};
        end
        narrow = wm || (xl == 32);
        ca = a;
        cb = b;
        if (narrow) begin
            ca = usi ? {32'h0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            cb = usi ? {32'h0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        lt = usi ? (ca < cb) : ($signed(ca) < $signed(cb));
        case (fun)
            F_SLT:   return lt ? 64'd1 : 64'd0;
            F_XOR:   r = a ^ b;
            F_OR:    r = a | b;
            F_AND:   r = a & b;
            F_MIN:   r = (lt || ca == cb) ? a : b;
            F_MAX:   r = lt ? b : a;
            default: r = 64'd0;
        endcase
        if (narrow) r = {{32{r[31]}}, r[31:0]};
        if (xl == 32) r = {32'h0, r[31:0]};
        return r;
    endfunction

    // One clock cycle of stimulus, entered and left 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [5:0] fun, input logic [6:0] rd,
                        input logic [63:0] a, input logic [63:0] b, input bit usi,
                        input bit word, input bit wr, input bit fl, input bit rs,
                        input bit useExp, input logic [63:0] exp);
        exp_t t;
        bus64.logCmp_execute_valid   = v;
        bus64.logCmp_execute_info    = {fun, rd, a, b, usi, word};
        bus64.logCmp_writeback_ready = wr;
        bus32.logCmp_execute_valid   = v;
        bus32.logCmp_execute_info    = {fun, rd, a[31:0], b[31:0], usi, word};
        bus32.logCmp_writeback_ready = wr;
        flush = fl;
        RST   = rs;
        #3;
        if (armed) begin
            check("ready64", 64'(bus64.logCmp_execute_ready), 64'(q64.size() < DEPTH64));
            check("valid64", 64'(bus64.logCmp_writeback_valid), 64'(q64.size() != 0));
            check("ready32", 64'(bus32.logCmp_execute_ready), 64'(q32.size() < DEPTH32));
            check("valid32", 64'(bus32.logCmp_writeback_valid), 64'(q32.size() != 0));
        end
        if (armed && !rs && !fl && v && bus64.logCmp_execute_ready) begin
            t.res = useExp ? exp : refModel(64, fun, a, b, usi, word);
            t.rd  = rd;
            q64.push_back(t);
        end
        if (armed && !rs && !fl && v && bus32.logCmp_execute_ready) begin
            t.res = refModel(32, fun, a, b, usi, word);
            t.rd  = rd;
            q32.push_back(t);
        end
        @(posedge CLK);
        #1;
        if (rs) armed = 1'b1;
    endtask

    task automatic idle(input bit wr, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0, wr, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    // Monitor: pops and compares whenever a writeback handshake occurs.
    always @(negedge CLK) begin
        exp_t e;
        if (armed && !RST && !flush) begin
            if (bus64.logCmp_writeback_valid && bus64.logCmp_writeback_ready) begin
                if (q64.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb64_extra: got res 0x%0h, expected no result", bus64.logCmp_res);
                end else begin
                    e = q64.pop_front();
                    check("res64", bus64.logCmp_res, e.res);
                    check("rd64", 64'(bus64.logCmp_rd0), 64'(e.rd));
                    $display("[TB] wb64 rd=0x%0h res=0x%0h", bus64.logCmp_rd0, bus64.logCmp_res);
                end
            end
            if (bus32.logCmp_writeback_valid && bus32.logCmp_writeback_ready) begin
                if (q32.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb32_extra: got res 0x%0h, expected no result", bus32.logCmp_res);
                end else begin
                    e = q32.pop_front();
                    check("res32", 64'(bus32.logCmp_res), e.res);
                    check("rd32", 64'(bus32.logCmp_rd0), 64'(e.rd));
                    $display("[TB] wb32 rd=0x%0h res=0x%0h", bus32.logCmp_rd0, bus32.logCmp_res);
                end
            end
        end
        if (RST || flush) begin
            q64.delete();
            q32.delete();
        end
    end

    initial begin
        logic [5:0]  fun;
        logic [63:0] a, b;
        int          k;

        RST = 1'b1;
        flush = 1'b0;
        bus64.logCmp_execute_valid = 1'b0;
        bus64.logCmp_execute_info = '0;
        bus64.logCmp_writeback_ready = 1'b0;
        bus32.logCmp_execute_valid = 1'b0;
        bus32.logCmp_execute_info = '0;
        bus32.logCmp_writeback_ready = 1'b0;
        @(posedge CLK);
        #1;
        armed = 1'b1;
        step(1'b0, 6'd0, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);

        // Deterministic storage after reset.
        check("rstRes64", bus64.logCmp_res, 64'd0);
        check("rstRd64", 64'(bus64.logCmp_rd0), 64'd0);
        check("rstRes32", 64'(bus32.logCmp_res), 64'd0);

        // Directed vectors with hand-computed 64-bit results.
        step(1, F_XOR, 7'h2A, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 1, 0, 0, 1, 64'hF0F0_0F0F_F0F0_0F0F);
        step(1, F_SLT, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1, 0, 0, 1, 64'd1);
        step(1, F_SLT, 7'h02, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 1, 0, 0, 1, 64'd0);
        step(1, F_SLT, 7'h03, 64'h0000_0001_8000_0000, 64'd0, 0, 1, 1, 0, 0, 1, 64'd1);
        step(1, F_MAX, 7'h04, 64'h7FFF_FFFF, 64'h8000_0000, 1, 1, 1, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
        step(1, F_MAX, 7'h05, 64'h7FFF_FFFF, 64'h8000_0000, 0, 1, 1, 0, 0, 1, 64'h0000_0000_7FFF_FFFF);
        step(1, F_MAX, 7'h06, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
        step(1, F_MIN, 7'h07, 64'h8000_0000_0000_0000, 64'd5, 0, 0, 1, 0, 0, 1, 64'h8000_0000_0000_0000);
        step(1, F_AND, 7'h08, 64'h0000_0000_8000_00FF, 64'h1234_5678_FFFF_0F0F, 0, 1, 1, 0, 0, 1, 64'hFFFF_FFFF_8000_000F);
        step(1, 6'd0,  7'h09, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1, 0, 0, 1, 0, 0, 1, 64'd0);
        idle(1'b1, 4);

        // Fill with writeback stalled; third op is held until after the first pop.
        step(1, F_OR, 7'h11, 64'h1, 64'h2, 0, 0, 0, 0, 0, 0, 64'd0);
        step(1, F_OR, 7'h12, 64'h4, 64'h8, 0, 0, 0, 0, 0, 0, 64'd0);
        step(1, F_OR, 7'h13, 64'h10, 64'h20, 0, 0, 0, 0, 0, 0, 64'd0);
        step(1, F_OR, 7'h13, 64'h10, 64'h20, 0, 0, 1, 0, 0, 0, 64'd0);
        step(1, F_OR, 7'h13, 64'h10, 64'h20, 0, 0, 1, 0, 0, 0, 64'd0);
        idle(1'b1, 6);

        // Flush with two entries queued and an op offered in the flush cycle.
        step(1, F_XOR, 7'h21, 64'h3, 64'h5, 0, 0, 0, 0, 0, 0, 64'd0);
        step(1, F_XOR, 7'h22, 64'h6, 64'h5, 0, 0, 0, 0, 0, 0, 64'd0);
        step(1, F_XOR, 7'h23, 64'h7, 64'h1, 0, 0, 0, 1, 0, 0, 64'd0);
        step(1, F_XOR, 7'h24, 64'hF0, 64'h0F, 0, 0, 1, 0, 0, 0, 64'd0);
        idle(1'b1, 4);

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 12000; n++) begin
            k = int'($urandom_range(0, 6));
            fun = (k == 0) ? 6'd0 : 6'(1 << (k - 1));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = {$urandom, $urandom};
                2:       b = {a[63:32], $urandom};
                default: b = {$urandom, a[31:0]};
            endcase
            step($urandom_range(0, 9) < 7, fun, 7'($urandom), a, b,
                 1'($urandom), 1'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0, 1'b0, 64'd0);
        end

        idle(1'b1, 10);
        check("drain64", 64'(q64.size()), 64'd0);
        check("drain32", 64'(q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
